// File: rtl/acl_motion_filter.sv
// Accelerometer conditioning: CDC-filtered sampling, windowed averaging,
// deadzone and clamp on X/Y, averaged Z tilt, one valid pulse per window.
module acl_motion_filter #(
    parameter int unsigned SAMPLE_DIV = 100000,
    parameter int unsigned AVG_LOG2   = 3,
    parameter int unsigned DEADZONE   = 2,
    parameter int unsigned MAX_STEP   = 3
) (
    input  logic               CLK100MHZ,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [14:0]        acl_data,
    output logic signed [3:0]  step_x,
    output logic signed [3:0]  step_y,
    output logic signed [4:0]  tilt_z,
    output logic               step_valid,
    output logic               busy
);

    localparam int unsigned AXIS_W = 5;
    localparam int unsigned WORD_W = 15;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned SUM_W  = AXIS_W + AVG_LOG2;
    localparam int unsigned CNT_W  = AVG_LOG2 + 1;
    localparam int unsigned TICK_W = $clog2(SAMPLE_DIV);
    localparam int unsigned WIN    = 2 ** AVG_LOG2;

    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WIN - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic signed [5:0] DZ        = 6'(DEADZONE);
    localparam logic signed [5:0] MX        = 6'(MAX_STEP);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CALC, S_OUT} state_e;

    state_e                     state_q, state_d;
    logic [TICK_W-1:0]          tick_cnt_q, tick_cnt_d;
    logic                       tick_c;
    logic [WORD_W-1:0]          s1_q, s2_q, stable_q, stable_d;
    logic signed [SUM_W-1:0]    sum_x_q, sum_x_d, sum_y_q, sum_y_d, sum_z_q, sum_z_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [STEP_W-1:0]   res_x_q, res_x_d, res_y_q, res_y_d;
    logic signed [AXIS_W-1:0]   res_z_q, res_z_d;
    logic signed [STEP_W-1:0]   step_x_q, step_x_d, step_y_q, step_y_d;
    logic signed [AXIS_W-1:0]   tilt_z_q, tilt_z_d;
    logic                       step_valid_q, step_valid_d;
    logic                       busy_q, busy_d;

    function automatic logic signed [SUM_W-1:0] ext(input logic [AXIS_W-1:0] a);
        return SUM_W'($signed(a));
    endfunction

    // Arithmetic shift floors toward -inf; the mean always fits in one axis width.
    function automatic logic signed [AXIS_W-1:0] mean(input logic signed [SUM_W-1:0] s);
        return AXIS_W'(s >>> AVG_LOG2);
    endfunction

    function automatic logic signed [STEP_W-1:0] shape(input logic signed [AXIS_W-1:0] m);
        logic signed [5:0] v;
        logic signed [5:0] r;
        v = {m[AXIS_W-1], m};
        if (v > DZ)       r = v - DZ;
        else if (v < -DZ) r = v + DZ;
        else              r = '0;
        if (r > MX)       r = MX;
        else if (r < -MX) r = -MX;
        return STEP_W'(r);
    endfunction

    assign tick_c = (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
        stable_d     = (s2_q == s1_q) ? s2_q : stable_q;
        sum_x_d      = sum_x_q;
        sum_y_d      = sum_y_q;
        sum_z_d      = sum_z_q;
        cnt_d        = cnt_q;
        res_x_d      = res_x_q;
        res_y_d      = res_y_q;
        res_z_d      = res_z_q;
        step_x_d     = step_x_q;
        step_y_d     = step_y_q;
        tilt_z_d     = tilt_z_q;
        step_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                sum_x_d = '0;
                sum_y_d = '0;
                sum_z_d = '0;
                cnt_d   = '0;
                if (enable) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                // Dropping enable abandons the partial window; IDLE clears it.
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (tick_c) begin
                    sum_x_d = sum_x_q + ext(stable_q[14:10]);
                    sum_y_d = sum_y_q + ext(stable_q[9:5]);
                    sum_z_d = sum_z_q + ext(stable_q[4:0]);
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) state_d = S_CALC;
                end
            end
            S_CALC: begin
                res_x_d = shape(mean(sum_x_q));
                res_y_d = shape(mean(sum_y_q));
                res_z_d = mean(sum_z_q);
                state_d = S_OUT;
            end
            S_OUT: begin
                step_x_d     = res_x_q;
                step_y_d     = res_y_q;
                tilt_z_d     = res_z_q;
                step_valid_d = 1'b1;
                sum_x_d      = '0;
                sum_y_d      = '0;
                sum_z_d      = '0;
                cnt_d        = '0;
                state_d      = enable ? S_ACCUM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            sum_x_q      <= '0;
            sum_y_q      <= '0;
            sum_z_q      <= '0;
            cnt_q        <= '0;
            res_x_q      <= '0;
            res_y_q      <= '0;
            res_z_q      <= '0;
            step_x_q     <= '0;
            step_y_q     <= '0;
            tilt_z_q     <= '0;
            step_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            s1_q         <= acl_data;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            sum_x_q      <= sum_x_d;
            sum_y_q      <= sum_y_d;
            sum_z_q      <= sum_z_d;
            cnt_q        <= cnt_d;
            res_x_q      <= res_x_d;
            res_y_q      <= res_y_d;
            res_z_q      <= res_z_d;
            step_x_q     <= step_x_d;
            step_y_q     <= step_y_d;
            tilt_z_q     <= tilt_z_d;
            step_valid_q <= step_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign step_x     = step_x_q;
    assign step_y     = step_y_q;
    assign tilt_z     = tilt_z_q;
    assign step_valid = step_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_acl_motion_filter.sv
// Directed bench for acl_motion_filter with a 10-clock sample period.
module tb_acl_motion_filter;

    localparam int unsigned DIV = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [14:0] acl_data;
    logic [3:0]  step_x;
    logic [3:0]  step_y;
    logic [4:0]  tilt_z;
    logic        step_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acl_motion_filter #(
        .SAMPLE_DIV(DIV),
        .AVG_LOG2  (3),
        .DEADZONE  (2),
        .MAX_STEP  (3)
    ) dut (
        .CLK100MHZ (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .acl_data  (acl_data),
        .step_x    (step_x),
        .step_y    (step_y),
        .tilt_z    (tilt_z),
        .step_valid(step_valid),
        .busy      (busy)
    );

    // Reference sample-period phase: 0 right after a tick edge.
    int tb_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cnt <= 0;
        else          tb_cnt <= (tb_cnt == DIV - 1) ? 0 : tb_cnt + 1;
    end

    // Data driver: 0 = hold, 1 = alternate once per sample period, 2 = toggle every clock.
    localparam logic [14:0] ALT_A = {5'd2, 5'h1D, 5'h1F};
    localparam logic [14:0] ALT_B = {5'd3, 5'h1D, 5'h1E};
    int          mode = 0;
    logic [14:0] hold = '0;
    bit          alt_ph = 1'b0;
    always @(negedge clk) begin
        case (mode)
            1: if (tb_cnt == 4) begin
                alt_ph   = ~alt_ph;
                acl_data = alt_ph ? ALT_B : ALT_A;
            end
            2: acl_data = (acl_data == 15'h5555) ? 15'h2AAA : 15'h5555;
            default: acl_data = hold;
        endcase
    end

    int sv_cnt = 0;
    bit sv_prev = 1'b0;
    bit sv_double = 1'b0;
    always @(negedge clk) begin
        if (step_valid === 1'b1) begin
            sv_cnt = sv_cnt + 1;
            if (sv_prev) sv_double = 1'b1;
        end
        sv_prev = (step_valid === 1'b1);
    end

    task automatic wait_sv(input int limit, output int clks, output bit ok);
        clks = 0;
        ok   = 1'b0;
        while (clks < limit && !ok) begin
            @(negedge clk);
            clks++;
            if (step_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        enable  = 1'b0;
        mode    = 0;
        repeat (4) begin
            hold = 15'($urandom);
            @(negedge clk);
        end
        checks++;
        if ({step_x, step_y, tilt_z} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outs got %h exp 0000", {step_x, step_y, tilt_z});
        end
        checks++;
        if (step_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b exp 0", step_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_constant;
        int clks;
        bit ok;
        logic [12:0] exp_o;
        exp_o = {4'h3, 4'hD, 5'h0F};
        hold = {5'd8, 5'h18, 5'd15};
        repeat (5) @(negedge clk);
        enable = 1'b1;
        wait_sv(200, clks, ok);
        checks++;
        if (!ok || {step_x, step_y, tilt_z} !== exp_o) begin
            errors++;
            $display("FAIL const_w1 got %h (seen %b) exp %h", {step_x, step_y, tilt_z}, ok, exp_o);
        end
        wait_sv(200, clks, ok);
        checks++;
        if (clks !== 80) begin
            errors++;
            $display("FAIL const_period got %0d exp 80", clks);
        end
        checks++;
        if ({step_x, step_y, tilt_z} !== exp_o) begin
            errors++;
            $display("FAIL const_w2 got %h exp %h", {step_x, step_y, tilt_z}, exp_o);
        end
    endtask

    task automatic test_deadzone;
        int clks;
        bit ok;
        logic [12:0] exp_o;
        exp_o = {4'h0, 4'hF, 5'h1E};
        alt_ph = 1'b0;
        mode   = 1;
        wait_sv(200, clks, ok);
        wait_sv(200, clks, ok);
        checks++;
        if (!ok || {step_x, step_y, tilt_z} !== exp_o) begin
            errors++;
            $display("FAIL deadzone_floor got %h (seen %b) exp %h", {step_x, step_y, tilt_z}, ok, exp_o);
        end
        @(negedge clk);
        checks++;
        if (step_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_width got %b exp 0", step_valid);
        end
    endtask

    task automatic test_enable_drop;
        int clks;
        bit ok;
        int tk;
        int sv0;
        logic [12:0] exp_o;
        exp_o = {4'h3, 4'h3, 5'h00};
        hold = {5'd15, 5'd15, 5'd0};
        mode = 0;
        wait_sv(200, clks, ok);
        wait_sv(200, clks, ok);
        checks++;
        if (!ok || {step_x, step_y, tilt_z} !== exp_o) begin
            errors++;
            $display("FAIL clamp_pos got %h (seen %b) exp %h", {step_x, step_y, tilt_z}, ok, exp_o);
        end
        tk = 0;
        while (tk < 5) begin
            @(negedge clk);
            if (tb_cnt == 0) tk++;
        end
        while (tb_cnt != 4) @(negedge clk);
        enable = 1'b0;
        sv0 = sv_cnt;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_busy got %b exp 0", busy);
        end
        checks++;
        if (sv_cnt !== sv0) begin
            errors++;
            $display("FAIL drop_no_valid got %0d pulses exp 0", sv_cnt - sv0);
        end
        checks++;
        if ({step_x, step_y, tilt_z} !== exp_o) begin
            errors++;
            $display("FAIL drop_hold got %h exp %h", {step_x, step_y, tilt_z}, exp_o);
        end
        hold = {5'd4, 5'h1C, 5'd7};
        repeat (10) @(negedge clk);
        while (tb_cnt != 4) @(negedge clk);
        enable = 1'b1;
        wait_sv(200, clks, ok);
        checks++;
        if (!ok || clks !== 78) begin
            errors++;
            $display("FAIL reenable_latency got %0d (seen %b) exp 78", clks, ok);
        end
        checks++;
        if ({step_x, step_y, tilt_z} !== {4'h2, 4'hE, 5'h07}) begin
            errors++;
            $display("FAIL reenable_outs got %h exp %h", {step_x, step_y, tilt_z}, {4'h2, 4'hE, 5'h07});
        end
    endtask

    task automatic test_reset_mid;
        int clks;
        bit ok;
        hold = {5'd8, 5'h18, 5'd15};
        repeat (35) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL accum_busy got %b exp 1", busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({step_x, step_y, tilt_z, step_valid, busy} !== 15'h0) begin
            errors++;
            $display("FAIL async_clear got %h exp 0000", {step_x, step_y, tilt_z, step_valid, busy});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_sv(200, clks, ok);
        checks++;
        if (!ok || clks !== 82) begin
            errors++;
            $display("FAIL resume_latency got %0d (seen %b) exp 82", clks, ok);
        end
        checks++;
        if ({step_x, step_y, tilt_z} !== {4'h3, 4'hD, 5'h0F}) begin
            errors++;
            $display("FAIL resume_outs got %h exp %h", {step_x, step_y, tilt_z}, {4'h3, 4'hD, 5'h0F});
        end
    endtask

    task automatic test_cdc;
        int clks;
        bit ok;
        hold = '0;
        wait_sv(200, clks, ok);
        wait_sv(200, clks, ok);
        checks++;
        if (!ok || {step_x, step_y, tilt_z} !== 13'h0) begin
            errors++;
            $display("FAIL zero_window got %h (seen %b) exp 0000", {step_x, step_y, tilt_z}, ok);
        end
        mode = 2;
        for (int w = 0; w < 2; w++) begin
            wait_sv(200, clks, ok);
            checks++;
            if (!ok || {step_x, step_y, tilt_z} !== 13'h0) begin
                errors++;
                $display("FAIL cdc_toggle_w%0d got %h (seen %b) exp 0000", w, {step_x, step_y, tilt_z}, ok);
            end
        end
        hold = {5'd5, 5'd0, 5'd0};
        mode = 0;
        wait_sv(200, clks, ok);
        wait_sv(200, clks, ok);
        checks++;
        if (!ok || {step_x, step_y, tilt_z} !== {4'h3, 4'h0, 5'h00}) begin
            errors++;
            $display("FAIL cdc_settled got %h (seen %b) exp %h", {step_x, step_y, tilt_z}, ok, {4'h3, 4'h0, 5'h00});
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_deadzone();
        test_enable_drop();
        test_reset_mid();
        test_cdc();
        checks++;
        if (sv_double !== 1'b0) begin
            errors++;
            $display("FAIL valid_back_to_back got %b exp 0", sv_double);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
